imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate-generation stage for the RV32I/RV64I core. It sits between fetch and decode/execute. It accepts an instruction word under a valid/ready handshake and classifies it into an immediate format, either from the opcode or from an external selector. It returns the sign- or zero-extended immediate at XLEN width, with a one-cycle registered latency and a 2-entry skid buffer, and keeps a saturating count of illegal encodings.

---
 rtl/imm_gen_stage.sv | 200 ++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_stage
// Purpose  : RV32I/RV64I immediate generator with a registered output stage
//            and a one-entry skid buffer, plus a saturating illegal counter.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [2:0]        in_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [2:0] C_FMT_I     = 3'b000;
  localparam logic [2:0] C_FMT_S     = 3'b001;
  localparam logic [2:0] C_FMT_B     = 3'b010;
  localparam logic [2:0] C_FMT_U     = 3'b011;
  localparam logic [2:0] C_FMT_J     = 3'b100;
  localparam logic [2:0] C_FMT_SHAMT = 3'b101;
  localparam logic [2:0] C_FMT_R     = 3'b110;
  localparam logic [2:0] C_FMT_ILL   = 3'b111;

  // ---------------------------------------------------------------- decode
  logic [2:0]      dec_fmt;
  logic [31:0]     dec_raw;
  logic            dec_sext;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            s;

  assign s = in_instr[31];

  always_comb begin
    dec_fmt = C_FMT_ILL;
    if (AUTO_DECODE != 0) begin
      case (in_instr[6:0])
        7'b0010011: dec_fmt = (in_instr[13:12] == 2'b01) ? C_FMT_SHAMT : C_FMT_I;
        7'b0000011,
        7'b1100111,
        7'b1110011: dec_fmt = C_FMT_I;
        7'b0100011: dec_fmt = C_FMT_S;
        7'b1100011: dec_fmt = C_FMT_B;
        7'b0110111,
        7'b0010111: dec_fmt = C_FMT_U;
        7'b1101111: dec_fmt = C_FMT_J;
        7'b0110011: dec_fmt = C_FMT_R;
        default:    dec_fmt = C_FMT_ILL;
      endcase
    end else begin
      dec_fmt = in_src;
    end
  end

  // Every signed format fits in 32 bits with its sign at bit 31, so the
  // immediate is assembled at 32 bits and widened once at the end.
  always_comb begin
    dec_raw  = 32'd0;
    dec_sext = 1'b1;
    case (dec_fmt)
      C_FMT_I: dec_raw = {{20{s}}, in_instr[31:20]};
      C_FMT_S: dec_raw = {{20{s}}, in_instr[31:25], in_instr[11:7]};
      C_FMT_B: dec_raw = {{19{s}}, s, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      C_FMT_U: dec_raw = {in_instr[31:12], 12'd0};
      C_FMT_J: dec_raw = {{11{s}}, s, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      C_FMT_SHAMT: begin
        dec_sext = 1'b0;
        dec_raw  = {26'd0, (XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
      end
      default: dec_raw = 32'd0;
    endcase
  end

  always_comb begin
    if (dec_sext) begin
      dec_imm = XLEN'($signed(dec_raw));
    end else begin
      dec_imm = XLEN'(dec_raw);
    end
    dec_illegal = (dec_fmt == C_FMT_ILL);
  end

  // ---------------------------------------------------------------- storage
  logic              out_valid_q,   out_valid_d;
  logic [31:0]       out_instr_q,   out_instr_d;
  logic [XLEN-1:0]   out_imm_q,     out_imm_d;
  logic [2:0]        out_fmt_q,     out_fmt_d;
  logic              out_illegal_q, out_illegal_d;
  logic              skid_valid_q,  skid_valid_d;
  logic [31:0]       skid_instr_q,  skid_instr_d;
  logic [XLEN-1:0]   skid_imm_q,    skid_imm_d;
  logic [2:0]        skid_fmt_q,    skid_fmt_d;
  logic              skid_illegal_q, skid_illegal_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  logic in_fire;
  logic out_fire;

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;
    illegal_cnt_d  = illegal_cnt_q;

    if (out_fire && out_illegal_q && !(&illegal_cnt_q)) begin
      illegal_cnt_d = illegal_cnt_q + 1'b1;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      // Output register is free this edge: skid has priority to keep order.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_instr_d   = skid_instr_q;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (in_fire) begin
        out_valid_d   = 1'b1;
        out_instr_d   = in_instr;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d   = 1'b1;
      skid_instr_d   = in_instr;
      skid_imm_d     = dec_imm;
      skid_fmt_d     = dec_fmt;
      skid_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_imm_q      <= '0;
      out_fmt_q      <= C_FMT_I;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= C_FMT_I;
      skid_illegal_q <= 1'b0;
      illegal_cnt_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_stage
// Purpose  : Self-checking bench: vector tables, directed handshake/flush/reset
//            sequences and a randomized queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imm_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: XLEN=32, opcode decode, 2-bit counter
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_out_instr, a_out_imm;
  logic [2:0]  a_in_src, a_out_fmt;
  logic [1:0]  a_cnt;

  // Instance B: XLEN=64, external format select
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_out_imm;
  logic [2:0]  b_in_src, b_out_fmt;
  logic [7:0]  b_cnt;

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_src(a_in_src),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
  );

  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_src(b_in_src),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: immediate value computed arithmetically from the ISA rules
  function automatic void ref_dec(input logic [31:0] ins, input logic [2:0] src,
                                  input bit auto_dec, input int xlen,
                                  output logic [2:0] fmt, output logic [63:0] imm);
    longint sx;
    logic [2:0] f3;
    sx = longint'($signed(ins));
    f3 = ins[14:12];
    if (auto_dec) begin
      case (ins[6:0])
        7'h13:             fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
        7'h03, 7'h67, 7'h73: fmt = 3'd0;
        7'h23:             fmt = 3'd1;
        7'h63:             fmt = 3'd2;
        7'h37, 7'h17:      fmt = 3'd3;
        7'h6F:             fmt = 3'd4;
        7'h33:             fmt = 3'd6;
        default:           fmt = 3'd7;
      endcase
    end else begin
      fmt = src;
    end
    case (fmt)
      3'd0: sx = sx >>> 20;
      3'd1: sx = ((sx >>> 25) * 32) + longint'(ins[11:7]);
      3'd2: sx = ((sx >>> 31) * 4096) + longint'(ins[7]) * 2048
                 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: sx = (sx >>> 12) * 4096;
      3'd4: sx = ((sx >>> 31) * 1048576) + longint'(ins[19:12]) * 4096
                 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd5: sx = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: sx = 0;
    endcase
    imm = sx;
    if (xlen == 32) imm[63:32] = 32'd0;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
  } exp_t;

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r = $urandom();
    if ($urandom_range(0, 4) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  vec_t vec_a [7];
  vec_t vec_b [7];
  exp_t q[$];
  exp_t e;
  int   mcnt;
  bit   o_fire, i_fire;
  logic [63:0] t_imm;
  logic [2:0]  t_fmt;

  initial begin
    vec_a[0] = '{32'hFFF00093, 3'd0, 3'd0, 64'hFFFFFFFF, 1'b0};
    vec_a[1] = '{32'hFE000EE3, 3'd0, 3'd2, 64'hFFFFFFFC, 1'b0};
    vec_a[2] = '{32'h123450B7, 3'd0, 3'd3, 64'h12345000, 1'b0};
    vec_a[3] = '{32'h41F0D093, 3'd0, 3'd5, 64'h0000001F, 1'b0};
    vec_a[4] = '{32'h00000000, 3'd0, 3'd7, 64'h00000000, 1'b1};
    vec_a[5] = '{32'hFE112E23, 3'd0, 3'd1, 64'hFFFFFFFC, 1'b0};
    vec_a[6] = '{32'h00C0006F, 3'd0, 3'd4, 64'h0000000C, 1'b0};
    vec_b[0] = '{32'hFFF00093, 3'd0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vec_b[1] = '{32'h80000037, 3'd3, 3'd3, 64'hFFFFFFFF80000000, 1'b0};
    vec_b[2] = '{32'h03F01013, 3'd5, 3'd5, 64'h000000000000003F, 1'b0};
    vec_b[3] = '{32'h12345678, 3'd7, 3'd7, 64'h0000000000000000, 1'b1};
    vec_b[4] = '{32'hFFFFFFFF, 3'd6, 3'd6, 64'h0000000000000000, 1'b0};
    vec_b[5] = '{32'h00000000, 3'd0, 3'd0, 64'h0000000000000000, 1'b0};
    vec_b[6] = '{32'hFE000EE3, 3'd2, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_instr = 0; a_in_src = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_instr = 0; b_in_src = 0;
    step(); step();
    chk("reset out_valid", a_out_valid, 0);
    chk("reset in_ready", a_in_ready, 1);
    chk("reset out_imm", a_out_imm, 0);
    chk("reset out_fmt", a_out_fmt, 0);
    chk("reset out_illegal", a_out_illegal, 0);
    chk("reset out_instr", a_out_instr, 0);
    chk("reset illegal_cnt", a_cnt, 0);
    rst = 1'b0;

    // Vector tables, one instruction at a time
    a_out_ready = 1; b_out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = 1; a_in_instr = vec_a[i].instr;
      b_in_valid = 1; b_in_instr = vec_b[i].instr; b_in_src = vec_b[i].src;
      step();
      a_in_valid = 0; b_in_valid = 0;
      chk("vecA valid", a_out_valid, 1);
      chk("vecA fmt", a_out_fmt, vec_a[i].fmt);
      chk("vecA imm", {32'd0, a_out_imm}, vec_a[i].imm);
      chk("vecA illegal", a_out_illegal, vec_a[i].ill);
      chk("vecA instr", a_out_instr, vec_a[i].instr);
      chk("vecB fmt", b_out_fmt, vec_b[i].fmt);
      chk("vecB imm", b_out_imm, vec_b[i].imm);
      chk("vecB illegal", b_out_illegal, vec_b[i].ill);
      step();
      chk("vecA drained", a_out_valid, 0);
    end

    // Back-to-back beq, lui, srai
    a_in_valid = 1;
    a_in_instr = 32'hFE000EE3; step();
    chk("b2b beq imm", a_out_imm, 32'hFFFFFFFC); chk("b2b beq fmt", a_out_fmt, 2);
    a_in_instr = 32'h123450B7; step();
    chk("b2b lui imm", a_out_imm, 32'h12345000); chk("b2b lui fmt", a_out_fmt, 3);
    a_in_instr = 32'h41F0D093; step();
    chk("b2b srai imm", a_out_imm, 32'h0000001F); chk("b2b srai fmt", a_out_fmt, 5);
    chk("b2b ready", a_in_ready, 1);
    a_in_valid = 0; step();
    chk("b2b idle", a_out_valid, 0);

    // Stall: 3 offered with out_ready low, 2 accepted
    a_out_ready = 0; a_in_valid = 1;
    a_in_instr = 32'h00100093; step();
    chk("stall ready1", a_in_ready, 1); chk("stall valid1", a_out_valid, 1);
    a_in_instr = 32'h00200093; step();
    chk("stall ready2", a_in_ready, 0);
    a_in_instr = 32'h00300093; step();
    chk("stall ready3", a_in_ready, 0);
    chk("stall hold instr", a_out_instr, 32'h00100093);
    chk("stall hold imm", a_out_imm, 1);
    a_out_ready = 1; step();
    chk("stall drain2", a_out_instr, 32'h00200093); chk("stall ready4", a_in_ready, 1);
    step();
    chk("stall drain3", a_out_instr, 32'h00300093); chk("stall imm3", a_out_imm, 3);
    a_in_valid = 0; step();
    chk("stall empty", a_out_valid, 0);

    // Five illegal words against a 2-bit saturating counter
    rst = 1; step(); rst = 0;
    a_out_ready = 1; a_in_valid = 1; a_in_instr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ill flag", a_out_illegal, 1);
      chk("ill imm", a_out_imm, 0);
      chk("ill cnt", a_cnt, (i > 3) ? 3 : i);
    end
    a_in_valid = 0; step();
    chk("ill cnt sat", a_cnt, 3);

    // Flush with both entries full and a new word offered
    a_out_ready = 0; a_in_valid = 1;
    a_in_instr = 32'hFFF00093; step();
    a_in_instr = 32'h123450B7; step();
    chk("flush full", a_in_ready, 0);
    a_flush = 1; a_in_instr = 32'h00500093; step();
    a_flush = 0; a_in_valid = 0;
    chk("flush valid", a_out_valid, 0); chk("flush ready", a_in_ready, 1);
    chk("flush cnt", a_cnt, 3);
    step();
    chk("flush dropped", a_out_valid, 0);
    // Flush while a word is handshaken with room available
    a_in_valid = 1; a_in_instr = 32'h00100093; step();
    a_flush = 1; a_in_instr = 32'h00200093; step();
    a_flush = 0; a_in_valid = 0;
    chk("flush1 valid", a_out_valid, 0);
    step();
    chk("flush1 dropped", a_out_valid, 0);

    // Reset mid-stream with both entries full
    a_in_valid = 1;
    a_in_instr = 32'hFFF00093; step();
    a_in_instr = 32'hFE000EE3; step();
    rst = 1; step(); rst = 0; a_in_valid = 0;
    chk("rst out_valid", a_out_valid, 0); chk("rst in_ready", a_in_ready, 1);
    chk("rst imm", a_out_imm, 0); chk("rst fmt", a_out_fmt, 0);
    chk("rst illegal", a_out_illegal, 0); chk("rst instr", a_out_instr, 0);
    chk("rst cnt", a_cnt, 0);

    // Randomized traffic against the queue model
    mcnt = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 40) == 0);
      a_in_instr  = rand_instr();
      ref_dec(a_in_instr, 3'd0, 1'b1, 32, t_fmt, t_imm);
      o_fire = (q.size() > 0) && a_out_ready;
      i_fire = a_in_valid && (q.size() < 2);
      if (o_fire && q[0].fmt == 3'd7 && mcnt < 3) mcnt++;
      if (a_flush) q.delete();
      else begin
        if (o_fire) void'(q.pop_front());
        if (i_fire) q.push_back('{a_in_instr, t_fmt, t_imm});
      end
      step();
      chk("rnd in_ready", a_in_ready, (q.size() < 2));
      chk("rnd out_valid", a_out_valid, (q.size() > 0));
      chk("rnd cnt", a_cnt, mcnt);
      if (q.size() > 0) begin
        e = q[0];
        chk("rnd instr", a_out_instr, e.instr);
        chk("rnd fmt", a_out_fmt, e.fmt);
        chk("rnd imm", {32'd0, a_out_imm}, e.imm);
        chk("rnd illegal", a_out_illegal, (e.fmt == 3'd7));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
